// File: rtl/approx_loa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_loa_pkg
// Description : Shared definitions for the Lower-part OR Adder (LOA).
//               Holds default sizing and a behavioural reference function.
//               The RTL uses the function in its assertions, and the bench
//               uses it as its model.
// Revision    : 1.0 - initial release
// ============================================================================
package approx_loa_pkg;

  localparam int LOA_WIDTH_DEFAULT  = 16;
  localparam int LOA_APPROX_DEFAULT = 8;
  localparam int LOA_MAX_WIDTH      = 64;

  typedef struct packed {
    logic                     cout;
    logic [LOA_MAX_WIDTH-1:0] sum;
  } loa_result_t;

  // Reference LOA for a w-bit adder whose low k bits are approximated.
  // The operands are zero-extended to 64 bits. Result bits at or above w
  // are zero.
  function automatic loa_result_t loa_ref(input logic [LOA_MAX_WIDTH-1:0] a,
                                          input logic [LOA_MAX_WIDTH-1:0] b,
                                          input int                       k,
                                          input int                       w);
    loa_result_t            r;
    logic                   c;
    logic [LOA_MAX_WIDTH-1:0] s;
    s = '0;
    c = 1'b0;
    // The carry guess comes from the top approximate bit pair. When k == w,
    // it also serves as the carry out.
    for (int i = 0; i < LOA_MAX_WIDTH; i++) begin
      if (k > 0 && i == k - 1) c = a[i] & b[i];
    end
    for (int i = 0; i < LOA_MAX_WIDTH; i++) begin
      if (i < w) begin
        if (i < k) begin
          s[i] = a[i] | b[i];
        end else begin
          s[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
      end
    end
    r.sum  = s;
    r.cout = c;
    return r;
  endfunction

  // Returns 1 when a computed {cout, sum} agrees with loa_ref.
  function automatic logic loa_check(input logic [LOA_MAX_WIDTH-1:0] a,
                                     input logic [LOA_MAX_WIDTH-1:0] b,
                                     input int                       k,
                                     input int                       w,
                                     input logic [LOA_MAX_WIDTH-1:0] sum,
                                     input logic                     cout);
    loa_result_t r;
    r = loa_ref(a, b, k, w);
    return (r.sum == sum) && (r.cout == cout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_loa_if.sv
`default_nettype none
// ============================================================================
// Module      : approx_loa_if
// Description : Operand/result bundle for approx_loa.
//               master : drives in_valid, a and b, and receives the result.
//               slave  : the adder side.
//               Signals: in_valid, a[WIDTH], b[WIDTH] (request)
//                        out_valid, sum[WIDTH], cout (response)
// Revision    : 1.0 - initial release
// ============================================================================
interface approx_loa_if
  import approx_loa_pkg::*;
#(
  parameter int WIDTH = LOA_WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, cout
  );

endinterface
`default_nettype wire

// File: rtl/approx_loa_rca.sv
`default_nettype none
// ============================================================================
// Module      : approx_loa_rca
// Description : Exact N-bit ripple-carry adder with carry in and carry out.
//               This is a single combinational path with no internal
//               pipelining.
//               Ports: i_a[N], i_b[N], i_cin -> o_sum[N], o_cout
// Revision    : 1.0 - initial release
// ============================================================================
module approx_loa_rca #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] i_a,
  input  wire logic [N-1:0] i_b,
  input  wire logic         i_cin,
  output logic      [N-1:0] o_sum,
  output logic              o_cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/approx_loa.sv
`default_nettype none
// ============================================================================
// Module      : approx_loa
// Description : Registered Lower-part OR Adder. The low APPROX_WIDTH bits
//               are the OR of the operands. The upper bits are an exact add
//               whose carry in is guessed from the top approximate bit pair.
//               The result is registered one cycle after in_valid.
//               Ports: clk, rst_n (async, active low)
//                      bus (slave): in_valid, a, b -> out_valid, sum, cout
// Revision    : 1.0 - initial release
// ============================================================================
module approx_loa
  import approx_loa_pkg::*;
#(
  parameter int WIDTH        = LOA_WIDTH_DEFAULT,
  parameter int APPROX_WIDTH = LOA_APPROX_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  approx_loa_if.slave bus
);

  localparam int c_k  = APPROX_WIDTH;
  localparam int c_hi = WIDTH - APPROX_WIDTH;

  logic [WIDTH-1:0] w_next_sum;
  logic             w_next_cout;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  if (WIDTH < 2 || WIDTH > LOA_MAX_WIDTH || APPROX_WIDTH < 0 || APPROX_WIDTH > WIDTH) begin : g_bad_params
    $error("approx_loa: illegal WIDTH/APPROX_WIDTH combination");
  end

  // The three configurations differ in whether an OR lane, an adder, or
  // both exist. Each branch elaborates only the slices that are legal for it.
  if (c_k == 0) begin : g_exact
    approx_loa_rca #(.N(WIDTH)) u_rca (
      .i_a    (bus.a),
      .i_b    (bus.b),
      .i_cin  (1'b0),
      .o_sum  (w_next_sum),
      .o_cout (w_next_cout)
    );
  end else if (c_k == WIDTH) begin : g_all_or
    assign w_next_sum  = bus.a | bus.b;
    // No upper adder exists, so the carry guess is reported as cout.
    assign w_next_cout = bus.a[WIDTH-1] & bus.b[WIDTH-1];
  end else begin : g_split
    logic w_c_guess;

    assign w_next_sum[c_k-1:0] = bus.a[c_k-1:0] | bus.b[c_k-1:0];
    // If both top approximate bits are set, an exact add would have carried
    // out of the low part. Other low-part carries are dropped.
    assign w_c_guess = bus.a[c_k-1] & bus.b[c_k-1];

    approx_loa_rca #(.N(c_hi)) u_rca (
      .i_a    (bus.a[WIDTH-1:c_k]),
      .i_b    (bus.b[WIDTH-1:c_k]),
      .i_cin  (w_c_guess),
      .o_sum  (w_next_sum[WIDTH-1:c_k]),
      .o_cout (w_next_cout)
    );
  end

  // out_valid follows in_valid. The result registers load only on valid
  // cycles, so the last result stays visible while the input is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_next_sum;
        r_cout <= w_next_cout;
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_out_valid;

`ifndef SYNTHESIS
  // The structural datapath must agree with the behavioural reference.
  always_ff @(posedge clk) begin
    if (rst_n && bus.in_valid) begin
      a_next_matches_ref : assert (loa_check(LOA_MAX_WIDTH'(bus.a), LOA_MAX_WIDTH'(bus.b),
                                             c_k, WIDTH,
                                             LOA_MAX_WIDTH'(w_next_sum), w_next_cout))
        else $error("approx_loa: datapath disagrees with loa_ref");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_loa.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_loa
// Description : Self-checking bench for approx_loa. It exercises the
//               default split configuration (K=8), the exact adder (K=0)
//               and the all-OR configuration (K=WIDTH), all at WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_loa;
  import approx_loa_pkg::*;

  localparam int c_width = 16;

  typedef struct {
    logic [c_width-1:0] a;
    logic [c_width-1:0] b;
    logic [c_width-1:0] exp_sum;
    logic               exp_cout;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [c_width-1:0] a;
  logic [c_width-1:0] b;

  int checks;
  int failures;

  approx_loa_if #(.WIDTH(c_width)) bus8 ();
  approx_loa_if #(.WIDTH(c_width)) bus0 ();
  approx_loa_if #(.WIDTH(c_width)) busw ();

  assign bus8.in_valid = in_valid;
  assign bus8.a        = a;
  assign bus8.b        = b;
  assign bus0.in_valid = in_valid;
  assign bus0.a        = a;
  assign bus0.b        = b;
  assign busw.in_valid = in_valid;
  assign busw.a        = a;
  assign busw.b        = b;

  approx_loa #(.WIDTH(c_width), .APPROX_WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  approx_loa #(.WIDTH(c_width), .APPROX_WIDTH(0)) u_dut_k0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  approx_loa #(.WIDTH(c_width), .APPROX_WIDTH(c_width)) u_dut_kw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  vec_t        vecs [9];
  loa_result_t r8;
  loa_result_t rw;
  logic [16:0] exact;

  initial begin
    checks   = 0;
    failures = 0;

    // Expected values for K=8, WIDTH=16, worked out by hand.
    vecs[0] = '{16'h00FF, 16'h0001, 16'h00FF, 1'b0}; // dropped low carry
    vecs[1] = '{16'h00FF, 16'h00FF, 16'h01FF, 1'b0}; // guess 1, low part approximated
    vecs[2] = '{16'h0080, 16'h0080, 16'h0180, 1'b0}; // boundary guess, error 128
    vecs[3] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0}; // exact
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1}; // overflow
    vecs[5] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[6] = '{16'h00AA, 16'h0055, 16'h00FF, 1'b0};
    vecs[7] = '{16'h1234, 16'h4321, 16'h5535, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 16'h0000, 1'b1}; // wraps modulo 2^16

    // Reset state
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", 64'(bus8.sum), 64'h0);
    check("reset_cout", 64'(bus8.cout), 64'h0);
    check("reset_out_valid", 64'(bus8.out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back to back
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      exact    = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sum", i), 64'(bus8.sum), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 64'(bus8.cout), 64'(vecs[i].exp_cout));
      check($sformatf("vec%0d_out_valid", i), 64'(bus8.out_valid), 64'h1);
      check($sformatf("vec%0d_k0_exact", i), 64'({bus0.cout, bus0.sum}), 64'(exact));
    end

    // Drop in_valid: out_valid falls, and sum/cout hold the last result (0x0000, cout 1)
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'h1357;
    b        = 16'h2468;
    @(posedge clk);
    #1;
    check("idle_out_valid", 64'(bus8.out_valid), 64'h0);
    check("idle_sum_hold", 64'(bus8.sum), 64'h0000);
    check("idle_cout_hold", 64'(bus8.cout), 64'h1);

    // Mid-stream reset clears outputs immediately without a clock edge
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_sum", 64'(bus8.sum), 64'h0);
    check("async_reset_cout", 64'(bus8.cout), 64'h0);
    check("async_reset_out_valid", 64'(bus8.out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a     = 16'h00AA;
    b     = 16'h0055;
    @(posedge clk);
    #1;
    check("post_reset_sum", 64'(bus8.sum), 64'h00FF);
    check("post_reset_out_valid", 64'(bus8.out_valid), 64'h1);

    // K=WIDTH corner: the result is pure OR, and cout is the top-bit AND
    @(negedge clk);
    a = 16'h00F0;
    b = 16'h0F0F;
    @(posedge clk);
    #1;
    check("kw_sum", 64'(busw.sum), 64'h0FFF);
    check("kw_cout", 64'(busw.cout), 64'h0);

    // Random pairs, back to back, on all three configurations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      r8       = loa_ref(64'(a), 64'(b), 8, c_width);
      rw       = loa_ref(64'(a), 64'(b), c_width, c_width);
      exact    = {1'b0, a} + {1'b0, b};
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_sum", i), 64'(bus8.sum), 64'(r8.sum[c_width-1:0]));
      check($sformatf("rnd%0d_cout", i), 64'(bus8.cout), 64'(r8.cout));
      check($sformatf("rnd%0d_out_valid", i), 64'(bus8.out_valid), 64'h1);
      check($sformatf("rnd%0d_k0_exact", i), 64'({bus0.cout, bus0.sum}), 64'(exact));
      check($sformatf("rnd%0d_kw", i), 64'({busw.cout, busw.sum}), 64'({rw.cout, rw.sum[c_width-1:0]}));
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_out_valid", 64'(bus8.out_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_loa.md
Name: approx_loa

Overview:
Registered Lower-part OR Adder (LOA) for error-tolerant datapaths such as image and DSP accumulation.
- Lower APPROX_WIDTH bits are approximated with a bitwise OR.
- Upper bits are added exactly, using a carry guessed from the top approximate bit pair.
- Operands are sampled on a valid strobe; the result appears one clock later.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range 2..64.
- APPROX_WIDTH, 8, number of low bits computed by OR; legal range 0..WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a and b are sampled on this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum and cout hold a new result.
- sum  output  WIDTH  approximate sum, truncated to WIDTH.
- cout  output  1  carry out of the exact upper part.

Behaviour:
- Let K = APPROX_WIDTH.
- Lower part: s_lo[K-1:0] = a[K-1:0] | b[K-1:0].
- Carry guess: c_guess = a[K-1] & b[K-1] when K >= 1; c_guess = 0 when K == 0.
- Upper part: {c_hi, s_hi} = a[WIDTH-1:K] + b[WIDTH-1:K] + c_guess. This is an exact (WIDTH-K)-bit add with carry out c_hi.
- Result: next_sum = {s_hi, s_lo}; next_cout = c_hi.
- K == WIDTH: no upper part; next_sum = a | b; next_cout = a[WIDTH-1] & b[WIDTH-1].
- K == 0: block is an exact adder, with cout as the true carry.
- Overflow wraps modulo 2^WIDTH; no saturation.
- Timing: on a rising clk with in_valid = 1, sum <= next_sum, cout <= next_cout, out_valid <= 1. Latency is exactly 1 cycle; throughput is 1 result per cycle.
- Rising clk with in_valid = 0: out_valid <= 0; sum and cout hold their last values.
- Reset: rst_n low asynchronously forces sum = 0, cout = 0, out_valid = 0, regardless of clk.
- Deassertion of rst_n is synchronized externally. The first result appears on the first edge with in_valid = 1 after release.
- Reset mid-stream discards any in-flight result.
- No X propagation: outputs are never X once reset has been applied.
- Error property, for any inputs: |next_sum - (a+b) mod 2^WIDTH| < 2^K, except when the wraparound itself differs.
- The upper-part combinational path is a plain exact adder; no pipelining inside.

Decomposition:
- Package approx_loa_pkg holds:
  - LOA_WIDTH_DEFAULT = 16;
  - LOA_APPROX_DEFAULT = 8;
  - a function loa_ref(a, b, k) returning {cout, sum}, shared by RTL assertions and the bench model.
- Sub-module approx_loa_rca: parameterized exact ripple-carry adder (N bits, carry in, carry out), used for the upper part.
- The OR lane, carry-guess logic, and output registers live in approx_loa.
- A generate block handles the K == 0 and K == WIDTH corner configurations.

Test Plan:
- Reset: rst_n=0 mid-stream with in_valid=1 -> sum=0, cout=0, out_valid=0 immediately. After release, a=0x00AA, b=0x0055 -> next cycle sum=0x00FF, out_valid=1.
- Carry loss (defaults): a=0x00FF, b=0x0001 -> sum=0x00FF (exact 0x0100, error 1). a=0x00FF, b=0x00FF -> sum=0x01FF (exact 0x01FE, error 1).
- Carry guess at boundary: a=0x0080, b=0x0080 -> sum=0x0180, cout=0 (error 128). a=0xAAAA, b=0x5555 -> sum=0xFFFF (exact).
- Overflow: a=0xFFFF, b=0xFFFF -> sum=0xFFFF, cout=1. a=0x0000, b=0xFFFF -> sum=0xFFFF, cout=0.
- Valid handling: back-to-back in_valid for 10 random pairs -> each result matches loa_ref one cycle later. Drop in_valid -> out_valid=0 next cycle, sum holds.
- Parameter corners: K=0 with random pairs -> sum equals exact a+b. K=WIDTH, a=0x00F0, b=0x0F0F -> sum=0x0FFF, cout=0.
